ddr3_wr_usr_logic: RTL and testbench

- Write-side DDR3 user logic, the counterpart of the DDR3 read path.
- Accepts a 24-bit pixel stream with a valid/ready handshake and packs 10 pixels into each 256-bit word.
- Buffers packed words in an internal FIFO and issues Avalon-MM write bursts to the DDR3 EMIF, starting at a programmed word address, until a programmed word count has been written.

---
 rtl/ddr3_wr_usr_logic.sv | 211 +++++++++++++++++++++
 tb/tb_ddr3_wr_usr_logic.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_wr_usr_logic.sv
// -----------------------------------------------------------------------------
// ddr3_wr_usr_logic
// Write-side DDR3 user logic. Packs a 24-bit pixel stream, 10 pixels per
// 256-bit word, into an internal FWFT FIFO. Whole words are written to the
// EMIF as Avalon-MM bursts, starting at a programmed word address, until a
// programmed number of words has been written.
//
// Ports
//   mem_clk, mem_rst        : clock, synchronous active-high reset
//   start_in                : one-cycle start pulse, honoured only when idle
//   start_addr_in           : first DDR3 word address of the job
//   to_write_word_in        : number of 256-bit words in the job
//   busy_out                : job in progress
//   write_done_out          : one-cycle pulse after the final beat
//   pix_data_in/valid/last  : pixel stream in; last forces a partial word
//   pix_ready_out           : pixel accepted when valid && ready
//   ddr3_emif_*             : Avalon-MM burst write master towards the EMIF
// -----------------------------------------------------------------------------
module ddr3_wr_usr_logic #(
   parameter int BURST_LEN    = 16,
   parameter int FIFO_DEPTH   = 32,
   parameter int PIX_PER_WORD = 10
) (
   input  logic         mem_clk,
   input  logic         mem_rst,
   input  logic         start_in,
   input  logic [21:0]  start_addr_in,
   input  logic [31:0]  to_write_word_in,
   output logic         busy_out,
   output logic         write_done_out,
   input  logic [23:0]  pix_data_in,
   input  logic         pix_valid_in,
   output logic         pix_ready_out,
   input  logic         pix_last_in,
   input  logic         ddr3_emif_ready,
   output logic         ddr3_emif_write,
   output logic [21:0]  ddr3_emif_addr,
   output logic [255:0] ddr3_emif_write_data,
   output logic [31:0]  ddr3_emif_byte_enable,
   output logic [4:0]   ddr3_emif_burst_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0] LAST_SLOT = 4'(PIX_PER_WORD - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_DATA, S_BURST, S_DONE} state_e;

   state_e        state_q;
   logic [21:0]   addr_q;
   logic [31:0]   words_left_q;
   logic [31:0]   words_total_q;
   logic [31:0]   words_packed_q;
   logic [3:0]    slot_q;
   logic [239:0]  pix_buf_q;
   logic [239:0]  pix_buf_d;
   logic [239:0]  fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] fifo_count_q;
   logic          write_q;
   logic [21:0]   emif_addr_q;
   logic [4:0]    burst_cnt_q;
   logic [4:0]    beat_cnt_q;
   logic          busy_q;
   logic          done_q;

   logic          fifo_full;
   logic          pix_ready;
   logic          pix_fire;
   logic          push;
   logic          pop;
   logic          start_accept;
   logic [4:0]    burst_len;

   assign fifo_full    = (fifo_count_q == CW'(FIFO_DEPTH));
   // Word-count limit keeps surplus pixels waiting upstream instead of dropping them.
   assign pix_ready    = busy_q && !fifo_full && (words_packed_q < words_total_q);
   assign pix_fire     = pix_valid_in && pix_ready;
   assign push         = pix_fire && ((slot_q == LAST_SLOT) || pix_last_in);
   assign pop          = write_q && ddr3_emif_ready;
   assign start_accept = (state_q == S_IDLE) && start_in;
   assign burst_len    = (words_left_q >= 32'(BURST_LEN)) ? 5'(BURST_LEN) : words_left_q[4:0];

   // Current word with the incoming pixel dropped into its slot; slots not yet
   // filled are still zero, which gives the zero-fill on a pix_last flush.
   // NOTE: combinational blocks assign a default first so no path leaves a latch.
   always_comb begin
      pix_buf_d = pix_buf_q;
      pix_buf_d[slot_q*24 +: 24] = pix_data_in;
   end

   // Pixel packer
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge mem_clk) begin
      if (mem_rst || start_accept) begin
         slot_q         <= '0;
         pix_buf_q      <= '0;
         words_packed_q <= '0;
      end else if (pix_fire) begin
         if (push) begin
            slot_q         <= '0;
            pix_buf_q      <= '0;
            words_packed_q <= words_packed_q + 32'd1;
         end else begin
            slot_q    <= slot_q + 4'd1;
            pix_buf_q <= pix_buf_d;
         end
      end
   end

   // FIFO storage. Bits [255:240] are always zero so they are not stored.
   // NOTE: the storage array has no reset; pointers and count alone define
   // which entries are valid, which lets it map onto RAM.
   always_ff @(posedge mem_clk) begin
      if (push) fifo_mem[wr_ptr_q] <= pix_buf_d;
   end

   always_ff @(posedge mem_clk) begin
      if (mem_rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      fifo_count_q <= fifo_count_q + CW'(1);
         else if (pop && !push) fifo_count_q <= fifo_count_q - CW'(1);
      end
   end

   // Job / burst control with registered EMIF outputs
   always_ff @(posedge mem_clk) begin
      if (mem_rst) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         words_left_q  <= '0;
         words_total_q <= '0;
         write_q       <= 1'b0;
         emif_addr_q   <= '0;
         burst_cnt_q   <= '0;
         beat_cnt_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start_in) begin
                  addr_q        <= start_addr_in;
                  words_left_q  <= to_write_word_in;
                  words_total_q <= to_write_word_in;
                  busy_q        <= 1'b1;
                  if (to_write_word_in == 32'd0) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_WAIT_DATA;
                  end
               end
            end
            S_WAIT_DATA: begin
               if (words_left_q == 32'd0) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (fifo_count_q >= CW'(burst_len)) begin
                  // Whole burst already buffered, so beats never stall on data.
                  write_q     <= 1'b1;
                  emif_addr_q <= addr_q;
                  burst_cnt_q <= burst_len;
                  beat_cnt_q  <= burst_len;
                  state_q     <= S_BURST;
               end
            end
            S_BURST: begin
               if (pop) begin
                  beat_cnt_q   <= beat_cnt_q - 5'd1;
                  words_left_q <= words_left_q - 32'd1;
                  if (beat_cnt_q == 5'd1) begin
                     write_q <= 1'b0;
                     addr_q  <= addr_q + 22'(burst_cnt_q);
                     if (words_left_q == 32'd1) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                     end else begin
                        state_q <= S_WAIT_DATA;
                     end
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_out              = busy_q;
   assign write_done_out        = done_q;
   assign pix_ready_out         = pix_ready;
   assign ddr3_emif_write       = write_q;
   assign ddr3_emif_addr        = emif_addr_q;
   assign ddr3_emif_burst_count = burst_cnt_q;
   assign ddr3_emif_byte_enable = {32{write_q}};
   // FIFO head is registered storage; gated so the bus reads zero when idle.
   assign ddr3_emif_write_data  = write_q ? {16'h0000, fifo_mem[rd_ptr_q]} : 256'd0;

endmodule

// File: tb/tb_ddr3_wr_usr_logic.sv
// -----------------------------------------------------------------------------
// tb_ddr3_wr_usr_logic
// Table of write jobs {address, word count, pixel pattern, ready pattern,
// expected bursts/beats} applied in a loop. A reference packer pushes expected
// words into a scoreboard queue as each pixel is accepted; a beat monitor pops
// and compares them. Expected burst headers come from a small address/length
// model. Hand sequences cover ignored restart, reset mid-burst and zero words.
// -----------------------------------------------------------------------------
module tb_ddr3_wr_usr_logic;

   logic         mem_clk = 1'b0;
   logic         mem_rst;
   logic         start_in;
   logic [21:0]  start_addr_in;
   logic [31:0]  to_write_word_in;
   logic         busy_out;
   logic         write_done_out;
   logic [23:0]  pix_data_in;
   logic         pix_valid_in;
   logic         pix_ready_out;
   logic         pix_last_in;
   logic         ddr3_emif_ready;
   logic         ddr3_emif_write;
   logic [21:0]  ddr3_emif_addr;
   logic [255:0] ddr3_emif_write_data;
   logic [31:0]  ddr3_emif_byte_enable;
   logic [4:0]   ddr3_emif_burst_count;

   ddr3_wr_usr_logic dut (
      .mem_clk               (mem_clk),
      .mem_rst               (mem_rst),
      .start_in              (start_in),
      .start_addr_in         (start_addr_in),
      .to_write_word_in      (to_write_word_in),
      .busy_out              (busy_out),
      .write_done_out        (write_done_out),
      .pix_data_in           (pix_data_in),
      .pix_valid_in          (pix_valid_in),
      .pix_ready_out         (pix_ready_out),
      .pix_last_in           (pix_last_in),
      .ddr3_emif_ready       (ddr3_emif_ready),
      .ddr3_emif_write       (ddr3_emif_write),
      .ddr3_emif_addr        (ddr3_emif_addr),
      .ddr3_emif_write_data  (ddr3_emif_write_data),
      .ddr3_emif_byte_enable (ddr3_emif_byte_enable),
      .ddr3_emif_burst_count (ddr3_emif_burst_count)
   );

   always #5 mem_clk = ~mem_clk;

   typedef struct {
      logic [21:0] addr;
      int          words;
      int          npix;
      int          last_at;    // 1-based pixel carrying pix_last, 0 = none
      int          rdy_mode;   // 0 always ready, 1 toggle, 2 random
      bit          extra;      // offer one surplus pixel afterwards
      int          exp_bursts;
      int          exp_beats;
   } vec_t;

   typedef struct {
      logic [21:0] addr;
      logic [4:0]  cnt;
   } burst_t;

   vec_t         vecs [6];
   logic [255:0] exp_word_q [$];
   burst_t       exp_burst_q [$];
   logic [239:0] mdl_buf;
   int           mdl_slot;
   int           n_vec = 0;
   int           n_miss = 0;
   int           mon_bursts, mon_beats, done_cnt;
   bit           drv_done;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] pixval(input int v, input int p);
      return 24'((v << 16) + p);
   endfunction

   task automatic model_reset();
      exp_word_q.delete();
      exp_burst_q.delete();
      mdl_buf  = '0;
      mdl_slot = 0;
   endtask

   task automatic model_accept(input logic [23:0] d, input logic last);
      mdl_buf[mdl_slot*24 +: 24] = d;
      if (mdl_slot == 9 || last) begin
         exp_word_q.push_back({16'h0000, mdl_buf});
         mdl_buf  = '0;
         mdl_slot = 0;
      end else begin
         mdl_slot++;
      end
   endtask

   task automatic plan_bursts(input logic [21:0] a, input int words);
      int          left = words;
      int          len;
      logic [21:0] ad = a;
      while (left > 0) begin
         len = (left > 16) ? 16 : left;
         exp_burst_q.push_back('{ad, 5'(len)});
         ad   += 22'(len);
         left -= len;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_write"},     256'(ddr3_emif_write), 256'(0));
      check({tag, "_busy"},      256'(busy_out), 256'(0));
      check({tag, "_done"},      256'(write_done_out), 256'(0));
      check({tag, "_pix_ready"}, 256'(pix_ready_out), 256'(0));
      check({tag, "_byte_en"},   256'(ddr3_emif_byte_enable), 256'(0));
      check({tag, "_data"},      ddr3_emif_write_data, 256'(0));
   endtask

   // Called on a falling edge; returns on the falling edge after the start edge.
   task automatic start_job(input logic [21:0] a, input int words);
      start_addr_in    = a;
      to_write_word_in = 32'(words);
      start_in         = 1'b1;
      @(negedge mem_clk);
      start_in = 1'b0;
   endtask

   task automatic drive_pixels(input int n, input int last_at, input bit extra, input int v);
      int p = 1;
      int budget = 0;
      int rdy_hits = 0;
      while (p <= n && budget < 4000) begin
         pix_valid_in = 1'b1;
         pix_data_in  = pixval(v, p);
         pix_last_in  = (p == last_at);
         if (pix_ready_out) begin
            model_accept(pix_data_in, pix_last_in);
            p++;
         end
         @(negedge mem_clk);
         budget++;
      end
      pix_valid_in = 1'b0;
      pix_last_in  = 1'b0;
      check("pixels_accepted", 256'(p - 1), 256'(n));
      if (extra) begin
         pix_valid_in = 1'b1;
         pix_data_in  = 24'hABCDEF;
         repeat (40) begin
            if (pix_ready_out) rdy_hits++;
            @(negedge mem_clk);
         end
         pix_valid_in = 1'b0;
         check("surplus_pixel_backpressured", 256'(rdy_hits), 256'(0));
      end
      drv_done = 1'b1;
   endtask

   task automatic run_monitor(input int mode);
      int           cyc = 0;
      int           rem = 0;
      int           last_xfer = -100;
      bit           in_burst = 1'b0;
      bit           stall = 1'b0;
      bit           prev_done = 1'b0;
      bit           finished = 1'b0;
      logic [255:0] h_data;
      logic [21:0]  h_addr;
      logic [4:0]   h_cnt;
      burst_t       b;
      while (cyc < 6000 && !finished) begin
         @(negedge mem_clk);
         cyc++;
         case (mode)
            0:       ddr3_emif_ready = 1'b1;
            1:       ddr3_emif_ready = (cyc % 2) == 1;
            default: ddr3_emif_ready = 1'($urandom_range(0, 1));
         endcase
         if (prev_done) check("busy_low_after_done", 256'(busy_out), 256'(0));
         prev_done = write_done_out;
         if (write_done_out) begin
            done_cnt++;
            check("done_after_last_beat", 256'(cyc - last_xfer), 256'(1));
         end
         if (stall) begin
            check("stall_hold_ctrl", 256'({ddr3_emif_write, ddr3_emif_addr, ddr3_emif_burst_count}),
                  256'({1'b1, h_addr, h_cnt}));
            check("stall_hold_data", ddr3_emif_write_data, h_data);
         end
         stall = 1'b0;
         if (ddr3_emif_write) begin
            check("byte_enable", 256'(ddr3_emif_byte_enable), 256'(32'hFFFF_FFFF));
            if (!in_burst) begin
               check("burst_expected", 256'(exp_burst_q.size() > 0), 256'(1));
               mon_bursts++;
               in_burst = 1'b1;
               rem = 32'(ddr3_emif_burst_count);
               if (exp_burst_q.size() > 0) begin
                  b = exp_burst_q.pop_front();
                  check("burst_addr", 256'(ddr3_emif_addr), 256'(b.addr));
                  check("burst_count", 256'(ddr3_emif_burst_count), 256'(b.cnt));
               end
            end
            if (ddr3_emif_ready) begin
               mon_beats++;
               last_xfer = cyc;
               check("word_expected", 256'(exp_word_q.size() > 0), 256'(1));
               if (exp_word_q.size() > 0) check("beat_data", ddr3_emif_write_data, exp_word_q.pop_front());
               rem--;
               if (rem <= 0) in_burst = 1'b0;
            end else begin
               stall  = 1'b1;
               h_data = ddr3_emif_write_data;
               h_addr = ddr3_emif_addr;
               h_cnt  = ddr3_emif_burst_count;
            end
         end else if (in_burst) begin
            check("write_held_in_burst", 256'(ddr3_emif_write), 256'(1));
            in_burst = 1'b0;
         end
         finished = drv_done && done_cnt > 0 && !busy_out && !write_done_out;
      end
      check("job_finished", 256'(finished), 256'(1));
   endtask

   task automatic run_vector(input int idx);
      vec_t v = vecs[idx];
      model_reset();
      plan_bursts(v.addr, v.words);
      mon_bursts = 0;
      mon_beats  = 0;
      done_cnt   = 0;
      drv_done   = 1'b0;
      ddr3_emif_ready = 1'b1;
      @(negedge mem_clk);
      start_job(v.addr, v.words);
      check("busy_after_start", 256'(busy_out), 256'(1));
      fork
         drive_pixels(v.npix, v.last_at, v.extra, idx);
         run_monitor(v.rdy_mode);
      join
      check("bursts_total", 256'(mon_bursts), 256'(v.exp_bursts));
      check("beats_total", 256'(mon_beats), 256'(v.exp_beats));
      check("done_pulses", 256'(done_cnt), 256'(1));
      check("words_left_in_scoreboard", 256'(exp_word_q.size()), 256'(0));
      check("bursts_left_in_scoreboard", 256'(exp_burst_q.size()), 256'(0));
   endtask

   // A second start while busy must not reload address or word count.
   task automatic seq_start_ignored();
      model_reset();
      plan_bursts(22'h000020, 1);
      mon_bursts = 0;
      mon_beats  = 0;
      done_cnt   = 0;
      drv_done   = 1'b0;
      ddr3_emif_ready = 1'b1;
      @(negedge mem_clk);
      start_job(22'h000020, 1);
      fork
         drive_pixels(10, 0, 1'b1, 7);
         run_monitor(0);
         begin
            repeat (3) @(negedge mem_clk);
            start_job(22'h000300, 5);
         end
      join
      check("restart_bursts", 256'(mon_bursts), 256'(1));
      check("restart_beats", 256'(mon_beats), 256'(1));
      check("restart_done_pulses", 256'(done_cnt), 256'(1));
   endtask

   task automatic seq_reset_and_zero();
      int beats = 0;
      int budget = 0;
      int dn = 0;
      model_reset();
      drv_done = 1'b0;
      ddr3_emif_ready = 1'b1;
      @(negedge mem_clk);
      start_job(22'h000500, 16);
      drive_pixels(160, 0, 1'b0, 9);
      while (beats < 5 && budget < 200) begin
         if (ddr3_emif_write && ddr3_emif_ready) beats++;
         @(negedge mem_clk);
         budget++;
      end
      check("beats_before_reset", 256'(beats), 256'(5));
      check("write_high_before_reset", 256'(ddr3_emif_write), 256'(1));
      mem_rst = 1'b1;
      @(negedge mem_clk);
      check_idle("midburst_reset");
      @(negedge mem_clk);
      mem_rst = 1'b0;
      repeat (6) begin
         @(negedge mem_clk);
         if (write_done_out || ddr3_emif_write) dn++;
      end
      check("no_activity_after_reset", 256'(dn), 256'(0));
      model_reset();
      start_job(22'h000123, 0);
      check("zero_words_done", 256'(write_done_out), 256'(1));
      check("zero_words_busy", 256'(busy_out), 256'(1));
      check("zero_words_write", 256'(ddr3_emif_write), 256'(0));
      @(negedge mem_clk);
      check("zero_words_done_end", 256'(write_done_out), 256'(0));
      check("zero_words_busy_end", 256'(busy_out), 256'(0));
      check("zero_words_no_write", 256'(ddr3_emif_write), 256'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      mem_rst          = 1'b1;
      start_in         = 1'b0;
      start_addr_in    = '0;
      to_write_word_in = '0;
      pix_data_in      = '0;
      pix_valid_in     = 1'b0;
      pix_last_in      = 1'b0;
      ddr3_emif_ready  = 1'b1;

      //             addr        words npix last mode extra bursts beats
      vecs[0] = '{22'h000100, 16, 160, 0,  0, 1'b0, 1, 16};
      vecs[1] = '{22'h000100, 20, 200, 0,  0, 1'b0, 2, 20};
      vecs[2] = '{22'h000200, 16, 160, 0,  1, 1'b0, 1, 16};
      vecs[3] = '{22'h000040, 2,  13,  13, 0, 1'b0, 1, 2};
      vecs[4] = '{22'h3FFFF0, 32, 320, 0,  0, 1'b1, 2, 32};
      vecs[5] = '{22'h000010, 3,  30,  10, 2, 1'b0, 1, 3};

      repeat (3) @(negedge mem_clk);
      check_idle("reset");
      check("reset_burst_count", 256'(ddr3_emif_burst_count), 256'(0));
      mem_rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vector(i);
      seq_start_ignored();
      seq_reset_and_zero();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
